// File: rtl/arbitro_mux2a1_l2_pkg.sv
// arbitro_mux2a1_l2_pkg: shared lane ids, default sizes and output-register reset values
package arbitro_mux2a1_l2_pkg;
  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  localparam logic RST_VALID = 1'b0;
  localparam logic RST_SEL = LANE0;
  // lane 1 counts as the last grant so lane 0 wins the first contention
  localparam logic RST_LAST = LANE1;
endpackage

// File: rtl/arbitro_mux2a1_l2_fifo.sv
// fifo_sinc_L2: synchronous per-lane FIFO with push, pop, head data, full and empty
// Ports: clk_4f/reset_L (sync active-low), push_i/data_i write side, pop_i/head_o read side,
// full_o when DEPTH entries are held, empty_o when none are held.
module fifo_sinc_L2 #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_4f,
  input  logic             reset_L,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             push_ok;
  assign full_o  = count_q == (PTR_W+1)'(DEPTH);
  assign empty_o = count_q == '0;
  assign head_o  = mem_q[rd_ptr_q];
  // a full FIFO still accepts a byte when its head leaves in the same cycle
  assign push_ok = push_i && (!full_o || pop_i);
  always_ff @(posedge clk_4f) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_i);
    end
  end
endmodule

// File: rtl/arbitro_mux2a1_l2.sv
// arbitro_mux2a1_l2: round-robin scheduler for the L2 2:1 byte mux with per-lane FIFOs
// Ports: clk_4f/reset_L (sync active-low); valid0/data_in0 and valid1/data_in1 lane writes;
// ready_out downstream accept; selectorL2/validout/dataout_muxL2 registered output word;
// full0/full1 lane FIFO full; ovf0/ovf1 sticky dropped-write flags.
module arbitro_mux2a1_l2
  import arbitro_mux2a1_l2_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_4f,
  input  logic             reset_L,
  input  logic             valid0,
  input  logic [WIDTH-1:0] data_in0,
  input  logic             valid1,
  input  logic [WIDTH-1:0] data_in1,
  input  logic             ready_out,
  output logic             selectorL2,
  output logic             validout,
  output logic [WIDTH-1:0] dataout_muxL2,
  output logic             full0,
  output logic             full1,
  output logic             ovf0,
  output logic             ovf1
);
  logic             valid_q, valid_d, sel_q, sel_d, last_q, last_d;
  logic             ovf0_q, ovf0_d, ovf1_q, ovf1_d;
  logic [WIDTH-1:0] data_q, data_d, head0, head1;
  logic             empty0, empty1, free, grant, do_pop, pop0, pop1;
  fifo_sinc_L2 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo0 (
    .clk_4f(clk_4f), .reset_L(reset_L), .push_i(valid0), .data_i(data_in0),
    .pop_i(pop0), .head_o(head0), .full_o(full0), .empty_o(empty0)
  );
  fifo_sinc_L2 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo1 (
    .clk_4f(clk_4f), .reset_L(reset_L), .push_i(valid1), .data_i(data_in1),
    .pop_i(pop1), .head_o(head1), .full_o(full1), .empty_o(empty1)
  );
  assign free   = !valid_q || ready_out;
  // with both lanes pending the lane not served last wins; otherwise the lone pending lane
  assign grant  = (!empty0 && !empty1) ? ~last_q : !empty1;
  assign do_pop = free && (!empty0 || !empty1);
  assign pop0   = do_pop && grant == LANE0;
  assign pop1   = do_pop && grant == LANE1;
  always_comb begin
    valid_d = free ? do_pop : valid_q;
    data_d  = do_pop ? (grant ? head1 : head0) : data_q;
    sel_d   = do_pop ? grant : sel_q;
    last_d  = do_pop ? grant : last_q;
    ovf0_d  = ovf0_q | (valid0 && full0 && !pop0);
    ovf1_d  = ovf1_q | (valid1 && full1 && !pop1);
  end
  always_ff @(posedge clk_4f) begin
    if (!reset_L) begin
      valid_q <= RST_VALID;
      data_q  <= '0;
      sel_q   <= RST_SEL;
      last_q  <= RST_LAST;
      ovf0_q  <= 1'b0;
      ovf1_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      ovf0_q  <= ovf0_d;
      ovf1_q  <= ovf1_d;
    end
  end
  assign validout      = valid_q;
  assign dataout_muxL2 = data_q;
  assign selectorL2    = sel_q;
  assign ovf0          = ovf0_q;
  assign ovf1          = ovf1_q;
endmodule
